// File: rtl/csa8_op_sequencer_if.sv
// csa8_op_sequencer_if: requester, result and external adder signals of the op sequencer
interface csa8_op_sequencer_if #(parameter int NBYTES = 4);
  localparam int W = 8 * NBYTES;
  logic [1:0] req, op_sub, gnt, done;
  logic [W-1:0] opa0, opb0, opa1, opb1, res;
  logic busy, res_cout, res_ovf, add_cin, add_cout;
  logic [7:0] add_a, add_b, add_sum;
  modport master(
    output req, op_sub, opa0, opb0, opa1, opb1, add_sum, add_cout,
    input gnt, busy, done, res, res_cout, res_ovf, add_a, add_b, add_cin
  );
  modport slave(
    input req, op_sub, opa0, opb0, opa1, opb1, add_sum, add_cout,
    output gnt, busy, done, res, res_cout, res_ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/csa8_op_sequencer.sv
// csa8_op_sequencer: round-robin byte-serial add/subtract sequencer driving an external 8-bit adder
module csa8_op_sequencer #(parameter int NBYTES = 4) (
  input logic clk,
  input logic rst,
  csa8_op_sequencer_if.slave bus
);
  localparam int W = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic carry, last, id, sel, sub, last_byte;
  logic [W-1:0] a, b;
  logic [1:0] pick;
  always_comb begin
    pick = bus.req == 2'b11 ? (last ? 2'b01 : 2'b10) : bus.req;
    sel = pick[1];
    sub = bus.op_sub[sel];
    last_byte = k == KW'(NBYTES - 1);
    state_n = state == IDLE ? (|bus.req ? RUN : IDLE) : state == RUN ? (last_byte ? DONE : RUN) : IDLE;
    bus.gnt = (state == IDLE && !rst) ? pick : 2'b00;
    bus.done = (state == DONE && !rst) ? (id ? 2'b10 : 2'b01) : 2'b00;
    bus.busy = state != IDLE;
    bus.add_a = state == RUN ? a[{k, 3'b000} +: 8] : 8'h00;
    bus.add_b = state == RUN ? b[{k, 3'b000} +: 8] : 8'h00;
    bus.add_cin = state == RUN ? carry : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      carry <= 1'b0;
      last <= 1'b1;
      id <= 1'b0;
      a <= '0;
      b <= '0;
      bus.res <= '0;
      bus.res_cout <= 1'b0;
      bus.res_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && |bus.req) begin
        id <= sel;
        a <= sel ? bus.opa1 : bus.opa0;
        b <= (sel ? bus.opb1 : bus.opb0) ^ {W{sub}};
        carry <= sub;
        k <= '0;
      end
      if (state == RUN) begin
        bus.res[{k, 3'b000} +: 8] <= bus.add_sum;
        carry <= bus.add_cout;
        if (last_byte) begin
          bus.res_cout <= bus.add_cout;
          bus.res_ovf <= (a[W-1] == b[W-1]) && (bus.add_sum[7] != a[W-1]);
        end else k <= k + 1'b1;
      end
      if (state == DONE) last <= id;
    end
  end
endmodule

// File: doc/csa8_op_sequencer.md
# csa8_op_sequencer

Sequencing controller for the team's shared 8-bit carry-select adder (combinational, `a + b + cin`). Two requesters are arbitrated round-robin onto the adder. Each granted operation is a multi-byte add or subtract, run one byte per cycle, LSB first, with a registered inter-byte carry. The adder instance sits outside this block and is wired to the `add_*` ports.

## Interface
Parameters:
- `NBYTES`, default 4: operand length in bytes (2..8); W = 8*NBYTES.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-requester request; level, held until granted.
- `op_sub`  in  2  per-requester op select: 0 = add, 1 = subtract (a − b).
- `opa0`, `opb0`  in  W each  requester 0 operands.
- `opa1`, `opb1`  in  W each  requester 1 operands.
- `gnt`  out  2  one-hot, 1-cycle pulse; operands sampled this cycle.
- `busy`  out  1  high from the cycle after the grant through the done cycle.
- `done`  out  2  one-hot, 1-cycle pulse; result valid for that requester.
- `res`  out  W  result; held until the next done.
- `res_cout`  out  1  carry out (for subtract: 1 = no borrow).
- `res_ovf`  out  1  signed two's-complement overflow.
- `add_a`, `add_b`  out  8 each  byte operands driven to the adder.
- `add_cin`  out  1  carry-in driven to the adder.
- `add_sum`  in  8  adder sum, same cycle.
- `add_cout`  in  1  adder carry out, same cycle.

## Operation
- States are IDLE, RUN and DONE. A byte counter k runs 0..NBYTES−1, and `last` (the last-granted requester) is held in a register.
- **IDLE**
  - If any `req` bit is high, grant one: a lone requester wins; on a tie, grant the requester ≠ `last`.
  - Pulse `gnt[i]`; latch opa, opb XOR {W{op_sub[i]}}, op_sub and the id; set the carry register to op_sub[i]; set k = 0; go to RUN.
- **RUN**
  - Drive `add_a` = A[8k+7:8k], `add_b` = B'[8k+7:8k] and `add_cin` = the carry register.
  - At the clock edge, write `add_sum` into res byte k and load `add_cout` into the carry register.
  - On the last byte (k = NBYTES−1), also capture:
    - `res_cout` = `add_cout`;
    - `res_ovf` = (A[W−1] == B'[W−1]) && (`add_sum`[7] != A[W−1]).
  - Then go to DONE; otherwise k++.
- **DONE**
  - Pulse `done[id]`; set `last` = id; go to IDLE.
  - No grant is issued in the DONE cycle.
- Outside RUN, `add_a`, `add_b` and `add_cin` are 0.
- `req` is sampled only in IDLE. `req` or operand changes after the grant cycle have no effect on the running operation.
- A requester still holding `req` after its done is re-arbitrated like any other request.
- Arithmetic is modulo 2^W. Subtraction is a + ~b + 1. The result carries no sign extension.
- Reset sets:
  - state IDLE, k = 0, carry register 0;
  - `last` = 1, so requester 0 wins the first tie;
  - `gnt` = 0, `done` = 0, `busy` = 0;
  - `res` = 0, `res_cout` = 0, `res_ovf` = 0;
  - adder drives 0.
- Reset asserted mid-operation aborts that operation: no done is issued and `res` is cleared to 0.

## Timing
- Grant in cycle T.
- RUN occupies cycles T+1 .. T+NBYTES; byte k is computed in cycle T+1+k.
- DONE is cycle T+NBYTES+1; `res` is valid from that cycle.
- The earliest next grant is T+NBYTES+2. Per-operation occupancy is NBYTES+2 cycles (6 at the default).
- `busy` is high in cycles T+1 .. T+NBYTES+1.
- The adder is combinational within a RUN cycle. The path from the registered operand byte through the adder to the `res`/carry registers must close in one clock.
- `gnt` and `done` are never high in the same cycle. At most one bit of each is high at a time.

## Test plan
- **Add with carry ripple:** requester 0 adds 0x00FFFFFF + 0x00000001 (NBYTES = 4).
  - `gnt`=01 at T; `done`=01 at T+5.
  - res = 0x01000000, `res_cout` = 0, `res_ovf` = 0.
  - `add_cin` = 1 in cycles T+2, T+3 and T+4.
- **Subtract:** requester 1 computes 5 − 7.
  - res = 0xFFFFFFFE, `res_cout` = 0, `res_ovf` = 0.
  - Also 7 − 5 gives res = 2, `res_cout` = 1.
- **Boundary values:**
  - 0x7FFFFFFF + 1 gives 0x80000000, `res_ovf` = 1, `res_cout` = 0.
  - 0xFFFFFFFF + 1 gives 0x00000000, `res_cout` = 1, `res_ovf` = 0.
  - 0x80000000 − 1 gives 0x7FFFFFFF, `res_ovf` = 1.
- **Fairness:** both `req` held high continuously from reset release.
  - Grants go 01, 10, 01, 10, six cycles apart.
  - Each done goes to the matching id.
- **Mid-operation reset:** assert `rst` in the cycle k = 2 is computed.
  - Next cycle: `busy` = 0, `done` never pulses, res = 0.
  - A following request completes correctly with normal latency.
- **Operand isolation:** change opa0/opb0 and deassert `req` in cycle T+1.
  - The result still reflects the operands sampled at T.
  - `add_a`/`add_b` show the latched bytes LSB first.
